// File: rtl/pw_auth_ctrl_pkg.sv
// Shared definitions for the door-lock password path: controller states,
// request mode encodings and the default keypad geometry, which the keypad
// digit collector reuses.
package pw_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      CHG_NEW  = 3'd2,
      CHG_CONF = 3'd3,
      LOCKED   = 3'd4
   } pw_state_e;

   localparam logic MODE_VERIFY = 1'b0;
   localparam logic MODE_CHANGE = 1'b1;

   localparam int DEF_DIGITS  = 32'sd4;
   localparam int DEF_DIGIT_W = 32'sd4;

   // Width of the failure counter; at least one bit even when lockout is off.
   function automatic int fail_cnt_w(input int max_fail);
      return ($clog2(max_fail + 32'sd1) < 32'sd1) ? 32'sd1 : $clog2(max_fail + 32'sd1);
   endfunction

endpackage

// File: rtl/pw_auth_ctrl_lock_timer.sv
// Lockout down-counter. A load pulse starts a lockout of LOCK_CYCLES cycles;
// expired is high on the cycle the counter reads zero, which is the last
// locked cycle, and stays high while idle.
module pw_lock_timer #(
   parameter int LOCK_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expired
);

   localparam int TW = (LOCK_CYCLES > 32'sd1) ? $clog2(LOCK_CYCLES) : 32'sd1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 32'sd1);

   logic [TW-1:0] count_r;

   // Reload on lockout entry, otherwise count down to zero and hold there
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {TW{1'b0}};
      end else if (load) begin
         count_r <= LOAD_VAL;
      end else if (count_r != {TW{1'b0}}) begin
         count_r <= count_r - TW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == {TW{1'b0}});

endmodule

// File: rtl/pw_auth_ctrl.sv
// Password authentication controller: verify and change-password flows over a
// packed multi-digit entry, with a consecutive-failure counter and a timed
// lockout. Result pulses appear one clock after the accepting edge.
module pw_auth_ctrl
   import pw_pkg::*;
#(
   parameter int DIGITS      = DEF_DIGITS,
   parameter int DIGIT_W     = DEF_DIGIT_W,
   parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PW = (DIGITS*DIGIT_W)'(16'h1234),
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 1000,
   localparam int PW_W       = DIGITS * DIGIT_W,
   localparam int FCW        = fail_cnt_w(MAX_FAIL)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_mode,
   input  logic [PW_W-1:0] pw_in,
   input  logic            cancel,
   output logic            req_ready,
   output logic            pw_ok,
   output logic            pw_fail,
   output logic            chg_done,
   output logic            chg_err,
   output logic            locked,
   output logic [FCW-1:0]  fail_cnt
);

   localparam logic [FCW-1:0] MAX_FAIL_C = FCW'(MAX_FAIL);

   pw_state_e       state_r;
   logic [PW_W-1:0] stored_pw_r;
   logic [PW_W-1:0] shadow_r;
   logic [PW_W-1:0] cand_r;
   logic            intent_r;

   logic            match_s;
   logic [FCW-1:0]  fail_inc_s;
   logic            lock_hit_s;
   logic            timer_load_s;
   logic            timer_expired_s;

   // Compare result, saturating failure increment and lockout trigger
   always_comb begin
      match_s    = (cand_r == stored_pw_r);
      fail_inc_s = fail_cnt;
      if (fail_cnt < MAX_FAIL_C) begin
         fail_inc_s = fail_cnt + FCW'(1);
      end else begin
         fail_inc_s = fail_cnt;
      end
      lock_hit_s   = (MAX_FAIL_C != {FCW{1'b0}}) && (fail_inc_s == MAX_FAIL_C);
      timer_load_s = (state_r == CHECK) && !match_s && lock_hit_s;
   end

   // Ready is decoded from state only so the collector can hold its entry
   always_comb begin
      case (state_r)
         IDLE, CHG_NEW, CHG_CONF: req_ready = 1'b1;
         default:                 req_ready = 1'b0;
      endcase
   end

   pw_lock_timer #(
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (timer_load_s),
      .expired (timer_expired_s)
   );

   // Main controller: state, password storage, failure count and pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         stored_pw_r <= DEFAULT_PW;
         shadow_r    <= {PW_W{1'b0}};
         cand_r      <= {PW_W{1'b0}};
         intent_r    <= MODE_VERIFY;
         pw_ok       <= 1'b0;
         pw_fail     <= 1'b0;
         chg_done    <= 1'b0;
         chg_err     <= 1'b0;
         locked      <= 1'b0;
         fail_cnt    <= {FCW{1'b0}};
      end else begin
         pw_ok    <= 1'b0;
         pw_fail  <= 1'b0;
         chg_done <= 1'b0;
         chg_err  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  cand_r   <= pw_in;
                  intent_r <= req_mode;
                  state_r  <= CHECK;
               end
            end
            CHECK: begin
               if (match_s) begin
                  pw_ok    <= 1'b1;
                  fail_cnt <= {FCW{1'b0}};
                  state_r  <= (intent_r == MODE_CHANGE) ? CHG_NEW : IDLE;
               end else begin
                  pw_fail  <= 1'b1;
                  fail_cnt <= fail_inc_s;
                  if (lock_hit_s) begin
                     locked  <= 1'b1;
                     state_r <= LOCKED;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            CHG_NEW: begin
               // cancel wins over a simultaneous entry
               if (cancel) begin
                  shadow_r <= {PW_W{1'b0}};
                  state_r  <= IDLE;
               end else if (req_valid) begin
                  shadow_r <= pw_in;
                  state_r  <= CHG_CONF;
               end
            end
            CHG_CONF: begin
               if (cancel) begin
                  shadow_r <= {PW_W{1'b0}};
                  state_r  <= IDLE;
               end else if (req_valid) begin
                  if (pw_in == shadow_r) begin
                     stored_pw_r <= shadow_r;
                     chg_done    <= 1'b1;
                  end else begin
                     chg_err     <= 1'b1;
                  end
                  shadow_r <= {PW_W{1'b0}};
                  state_r  <= IDLE;
               end
            end
            LOCKED: begin
               if (timer_expired_s) begin
                  locked   <= 1'b0;
                  fail_cnt <= {FCW{1'b0}};
                  state_r  <= IDLE;
               end
            end
            default: begin
               locked  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pw_auth_ctrl.sv
// Self-checking bench for pw_auth_ctrl: directed steps followed by random
// operations, checked against a behavioural model of the stored password,
// failure count and lockout length. A second instance covers a 6-digit
// configuration with lockout disabled.
module tb_pw_auth_ctrl;

   localparam int LOCK = 1000;
   localparam int MAXF = 3;
   localparam logic [23:0] PW6 = 24'h123456;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_mode, cancel;
   logic [15:0] pw_in;
   logic        req_ready, pw_ok, pw_fail, chg_done, chg_err, locked;
   logic [1:0]  fail_cnt;

   logic        req_valid6, req_mode6, cancel6;
   logic [23:0] pw_in6;
   logic        req_ready6, pw_ok6, pw_fail6, chg_done6, chg_err6, locked6;
   logic [0:0]  fail_cnt6;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_pw;
   int          m_fail;

   always #5 clk = ~clk;

   pw_auth_ctrl #(
      .DIGITS(4), .DIGIT_W(4), .DEFAULT_PW(16'h1234), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCK)
   ) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_mode(req_mode),
      .pw_in(pw_in), .cancel(cancel), .req_ready(req_ready), .pw_ok(pw_ok),
      .pw_fail(pw_fail), .chg_done(chg_done), .chg_err(chg_err), .locked(locked),
      .fail_cnt(fail_cnt)
   );

   pw_auth_ctrl #(
      .DIGITS(6), .DIGIT_W(4), .DEFAULT_PW(PW6), .MAX_FAIL(0), .LOCK_CYCLES(LOCK)
   ) u_dut6 (
      .clk(clk), .reset(reset), .req_valid(req_valid6), .req_mode(req_mode6),
      .pw_in(pw_in6), .cancel(cancel6), .req_ready(req_ready6), .pw_ok(pw_ok6),
      .pw_fail(pw_fail6), .chg_done(chg_done6), .chg_err(chg_err6), .locked(locked6),
      .fail_cnt(fail_cnt6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic pulses_idle(input string tag);
      chk({tag, "_pulses"}, {28'd0, pw_ok, pw_fail, chg_done, chg_err}, 32'd0);
   endtask

   // Submit one request once ready; afterwards the controller is checking.
   task automatic request(input logic mode, input logic [15:0] pw);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk("ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_mode  = mode;
      pw_in     = pw;
      tick();
      req_valid = 1'b0;
      req_mode  = 1'($urandom_range(0, 1));
      pw_in     = 16'($urandom());
      chk("check_ready", {31'd0, req_ready}, 32'd0);
      pulses_idle("check");
   endtask

   // Lockout must last exactly LOCK cycles and ignore every input.
   task automatic lockout();
      int n;
      n = 0;
      while (locked === 1'b1 && n < 2000) begin
         chk("lock_ready", {31'd0, req_ready}, 32'd0);
         req_valid = 1'($urandom_range(0, 1));
         cancel    = 1'($urandom_range(0, 1));
         req_mode  = 1'($urandom_range(0, 1));
         pw_in     = ($urandom_range(0, 1) == 1) ? m_pw : 16'($urandom());
         n++;
         tick();
      end
      req_valid = 1'b0;
      cancel    = 1'b0;
      m_fail    = 0;
      chk("lock_len", n, LOCK);
      chk("lock_cnt_clr", {30'd0, fail_cnt}, 32'd0);
      chk("lock_ready_after", {31'd0, req_ready}, 32'd1);
      pulses_idle("lock_end");
   endtask

   task automatic check_result(input logic [15:0] pw, output bit matched);
      bit lock_now;
      tick();
      matched = (pw == m_pw);
      if (matched) m_fail = 0;
      else if (m_fail < MAXF) m_fail++;
      lock_now = !matched && (m_fail == MAXF);
      chk("pw_ok", {31'd0, pw_ok}, {31'd0, matched});
      chk("pw_fail", {31'd0, pw_fail}, {31'd0, !matched});
      chk("fail_cnt", {30'd0, fail_cnt}, m_fail);
      chk("locked", {31'd0, locked}, {31'd0, lock_now});
      chk("no_chg_pulse", {30'd0, chg_done, chg_err}, 32'd0);
      if (lock_now) begin
         lockout();
      end else begin
         tick();
         pulses_idle("after_result");
      end
   endtask

   task automatic verify(input logic [15:0] pw);
      bit m;
      request(1'b0, pw);
      check_result(pw, m);
   endtask

   // cancel_at: 0 none, 1 with the new entry, 2 with the confirmation
   task automatic change(input logic [15:0] auth, input logic [15:0] new_pw,
                         input logic [15:0] conf, input int cancel_at);
      bit m;
      bit same;
      request(1'b1, auth);
      check_result(auth, m);
      if (m) begin
         chk("chg_new_ready", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b1;
         req_mode  = 1'($urandom_range(0, 1));
         pw_in     = new_pw;
         cancel    = (cancel_at == 1);
         tick();
         req_valid = 1'b0;
         cancel    = 1'b0;
         pulses_idle("chg_new");
         if (cancel_at != 1) begin
            chk("chg_conf_ready", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b1;
            pw_in     = conf;
            cancel    = (cancel_at == 2);
            tick();
            req_valid = 1'b0;
            cancel    = 1'b0;
            if (cancel_at == 2) begin
               pulses_idle("cancel_conf");
            end else begin
               same = (conf == new_pw);
               chk("chg_done", {31'd0, chg_done}, {31'd0, same});
               chk("chg_err", {31'd0, chg_err}, {31'd0, !same});
               chk("chg_no_ok", {30'd0, pw_ok, pw_fail}, 32'd0);
               chk("chg_cnt", {30'd0, fail_cnt}, m_fail);
               if (same) m_pw = new_pw;
               tick();
               pulses_idle("chg_end");
            end
         end
      end
   endtask

   task automatic verify6(input logic [23:0] pw);
      int  n;
      bit  exp_ok;
      n = 0;
      while (req_ready6 !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk("d6_ready_wait", {31'd0, req_ready6}, 32'd1);
      exp_ok     = (pw == PW6);
      req_valid6 = 1'b1;
      pw_in6     = pw;
      tick();
      req_valid6 = 1'b0;
      tick();
      chk("d6_ok", {31'd0, pw_ok6}, {31'd0, exp_ok});
      chk("d6_fail", {31'd0, pw_fail6}, {31'd0, !exp_ok});
      chk("d6_cnt", {31'd0, fail_cnt6}, 32'd0);
      chk("d6_locked", {31'd0, locked6}, 32'd0);
      tick();
   endtask

   initial begin
      bit          m;
      int          op;
      logic [15:0] r;
      logic [15:0] bad;
      logic [23:0] r6;

      reset      = 1'b1;
      req_valid  = 1'b0; req_mode  = 1'b0; cancel  = 1'b0; pw_in  = 16'h0000;
      req_valid6 = 1'b0; req_mode6 = 1'b0; cancel6 = 1'b0; pw_in6 = 24'h000000;
      m_pw   = 16'h1234;
      m_fail = 0;
      tick();
      tick();
      pulses_idle("rst");
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_cnt", {30'd0, fail_cnt}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      reset = 1'b0;
      tick();

      verify(16'h1234);
      verify(16'h1235);
      verify(16'h1234);
      verify(16'h0000);
      verify(16'h1230);
      verify(16'hFFFF);
      verify(16'h1234);

      change(16'h1234, 16'h5678, 16'h5678, 0);
      verify(16'h1234);
      verify(16'h5678);

      // Reset in the middle of a change reverts to the power-on password
      request(1'b1, 16'h5678);
      check_result(16'h5678, m);
      reset = 1'b1;
      #2;
      pulses_idle("mid_rst");
      chk("mid_rst_locked", {31'd0, locked}, 32'd0);
      chk("mid_rst_cnt", {30'd0, fail_cnt}, 32'd0);
      tick();
      reset  = 1'b0;
      m_pw   = 16'h1234;
      m_fail = 0;
      tick();
      verify(16'h5678);
      verify(16'h1234);

      verify(16'h9999);
      change(16'h1234, 16'h5678, 16'h5679, 0);
      verify(16'h5678);
      verify(16'h1234);

      change(16'h1234, 16'h4321, 16'h4321, 2);
      verify(16'h4321);
      verify(16'h1234);
      change(16'h1234, 16'h4321, 16'h4321, 1);
      verify(16'h1234);

      for (int i = 0; i < 40; i++) begin
         op  = int'($urandom_range(0, 4));
         r   = 16'($urandom());
         bad = m_pw ^ ((r == 16'h0000) ? 16'h0001 : r);
         case (op)
            0:       verify(m_pw);
            1:       verify(bad);
            2:       change(m_pw, r, r, 0);
            3:       change(m_pw, r, r ^ 16'h0100, 0);
            default: change(($urandom_range(0, 1) == 1) ? m_pw : bad, r, r,
                            int'($urandom_range(1, 2)));
         endcase
      end
      verify(m_pw);

      for (int i = 0; i < 10; i++) begin
         r6 = 24'($urandom());
         if (r6 == PW6) r6 = PW6 ^ 24'h000001;
         verify6(r6);
      end
      verify6(24'h023456);
      verify6(24'h123457);
      verify6(PW6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pw_auth_ctrl.md
Name: pw_auth_ctrl

Overview:
Parametrised password authentication controller for the door-lock datapath. It sits between the keypad digit collector and the door actuator/display FSM.
- Checks a packed multi-digit entry against a stored password.
- Supports an authenticated change-password flow with confirmation entry.
- Enforces a timed lockout after repeated failures.
- Generalises the fixed 4-digit, single-cycle compare with configurable digit count and width, a request handshake, and failure/lockout policy.

Parameters:
DIGITS, 4, number of password digits
DIGIT_W, 4, bits per digit; PW_W = DIGITS*DIGIT_W
DEFAULT_PW, 16'h1234, power-on password, PW_W bits, most significant digit entered first
MAX_FAIL, 3, consecutive failures that trigger lockout; 0 disables lockout
LOCK_CYCLES, 1000, lockout duration in clk cycles, >=1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  entry strobe; accepted only when req_ready=1
req_mode  in  1  0=verify, 1=change request; sampled only in IDLE
pw_in  in  PW_W  packed entered digits, sampled with accepted req_valid
cancel  in  1  abort change flow
req_ready  out  1  high only in IDLE, CHG_NEW, CHG_CONF
pw_ok  out  1  one-cycle pulse: verify or change-auth matched
pw_fail  out  1  one-cycle pulse: verify or change-auth mismatched
chg_done  out  1  one-cycle pulse: new password committed
chg_err  out  1  one-cycle pulse: confirmation mismatch
locked  out  1  high for the whole lockout
fail_cnt  out  FCW  consecutive failure count, FCW = clog2(MAX_FAIL+1), min 1

Behaviour:
- Reset (async, active-high):
  - stored_pw=DEFAULT_PW, shadow=0, state=IDLE, fail_cnt=0, lock timer=0.
  - All pulse outputs and locked are 0.
  - Reset mid-flow discards any pending change.
- States: IDLE, CHECK, CHG_NEW, CHG_CONF, LOCKED.
- IDLE, accepted req with mode 0:
  - pw_in is registered; go to CHECK with intent=verify.
  - Next cycle: exactly one of pw_ok/pw_fail pulses. Result latency is 1 cycle after acceptance.
  - Return to IDLE or LOCKED.
- IDLE, accepted req with mode 1:
  - pw_in is the current password; go to CHECK with intent=change.
  - Match: pw_ok pulses, go to CHG_NEW.
  - Mismatch: pw_fail pulses; treated as an ordinary failure.
- Match (either intent): fail_cnt cleared to 0.
- Mismatch:
  - fail_cnt increments, saturating at MAX_FAIL.
  - If the new count equals MAX_FAIL and MAX_FAIL!=0: go to LOCKED, locked=1 from the next cycle, timer loaded with LOCK_CYCLES-1.
- CHG_NEW, accepted req: pw_in copied to shadow (req_mode ignored); go to CHG_CONF. No output pulse.
- CHG_CONF, accepted req:
  - pw_in==shadow: stored_pw<=shadow on that edge, chg_done pulses next cycle, go to IDLE.
  - Otherwise: chg_err pulses, stored_pw unchanged, go to IDLE.
  - Confirmation mismatch does not affect fail_cnt.
- cancel:
  - In CHG_NEW or CHG_CONF: go to IDLE, shadow cleared, no pulse.
  - cancel and req_valid in the same cycle: cancel wins and the request is dropped.
  - cancel in other states: ignored.
- LOCKED:
  - req_ready=0; req_valid and cancel ignored.
  - Timer decrements each cycle. On the cycle it reads 0: go to IDLE, locked=0, fail_cnt=0.
  - Lockout lasts exactly LOCK_CYCLES cycles.
- CHECK: req_ready=0; any req_valid is ignored, not queued.
- Compare is a full PW_W-bit equality. The digit value range is not checked.
- Outputs are registered; no combinational path from inputs to outputs except req_ready, which is decoded from state only.
- Pulse outputs are never asserted simultaneously.

Decomposition:
- Shared package pw_pkg holds:
  - state enum (IDLE, CHECK, CHG_NEW, CHG_CONF, LOCKED)
  - mode constants MODE_VERIFY=1'b0, MODE_CHANGE=1'b1
  - default DIGITS/DIGIT_W values, reused by the keypad collector
- One natural sub-module: pw_lock_timer.
  - Parameter LOCK_CYCLES; inputs load, clk, reset; output expired.
  - The down-counter width is clog2(LOCK_CYCLES).

Test Plan:
- Reset, then verify with 16'h1234 -> pw_ok pulse exactly 1 cycle after acceptance, fail_cnt=0. Verify with 16'h1235 -> pw_fail, fail_cnt=1.
- Three consecutive wrong verifies (MAX_FAIL=3) -> locked=1 for exactly 1000 cycles, req_ready=0, requests ignored; afterwards locked=0 and fail_cnt=0. A correct verify then gives pw_ok.
- Change flow:
  - Change request with 16'h1234 -> pw_ok; then 16'h5678; then 16'h5678 -> chg_done.
  - Verify 16'h1234 -> pw_fail; verify 16'h5678 -> pw_ok.
- Change with mismatched confirmation (new 16'h5678, confirm 16'h5679) -> chg_err, stored password still 16'h1234, fail_cnt unchanged.
- cancel asserted together with req_valid in CHG_CONF -> return to IDLE, no pulse, stored password unchanged. Assert reset mid-CHG_NEW -> password reverts to DEFAULT_PW.
- Parameter sweep: DIGITS=6, DIGIT_W=4, MAX_FAIL=0 -> 10 wrong verifies never lock, fail_cnt stays saturated at 0 width-safely, 24-bit compare is correct.
